// File: rtl/i2c_pkg.sv
// i2c_pkg: phase encoding and speed-mode constants shared by the I2C SCL phase generator
package i2c_pkg;
    typedef enum logic [2:0] {PH_IDLE, PH_Q0, PH_Q1, PH_Q2, PH_Q3} scl_phase_t;
    localparam logic I2C_MODE_STD  = 1'b0;
    localparam logic I2C_MODE_FAST = 1'b1;
endpackage

// File: rtl/i2c_stretch_timer.sv
// i2c_stretch_timer: counts cycles SCL is held low by a slave and flags the timeout cycle
module i2c_stretch_timer #(
    parameter int STRETCH_TO = 100000,
    parameter int TO_W       = 17
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic timeout
);
    logic [TO_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) r_cnt <= '0;
        else if (inc) r_cnt <= r_cnt + 1'b1;
    end

    assign timeout = inc && (r_cnt == TO_W'(STRETCH_TO - 1));
endmodule

// File: rtl/i2c_scl_phase_gen.sv
// i2c_scl_phase_gen: I2C master SCL quarter-phase generator with clock-stretch handling.
// Define I2C_SCL_SYNC_EN to pass scl_in through a 2-flop synchroniser before use.
module i2c_scl_phase_gen
    import i2c_pkg::*;
#(
    parameter int DIV_STD    = 250,
    parameter int DIV_FAST   = 63,
    parameter int CNT_W      = 16,
    parameter int STRETCH_TO = 100000,
    parameter int TO_W       = 17
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic mode,
    input  logic scl_in,
    output logic scl_oe,
    output logic data_clk,
    output logic switch_range,
    output logic stretching,
    output logic bit_done,
    output logic stretch_timeout,
    output logic busy
);
    scl_phase_t       r_phase, w_phase_nx;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx, w_div_m1;
    logic             r_div_sel, w_div_sel_nx;
    logic             w_scl_s, w_last, w_q2_low;

`ifdef I2C_SCL_SYNC_EN
    logic [1:0] r_sync;
    always_ff @(posedge clk) r_sync <= rst ? 2'b11 : {r_sync[0], scl_in};
    assign w_scl_s = r_sync[1];
`else
    assign w_scl_s = scl_in;
`endif

    assign w_div_m1 = r_div_sel ? CNT_W'(DIV_FAST - 1) : CNT_W'(DIV_STD - 1);
    assign w_last   = r_cnt == w_div_m1;
    assign w_q2_low = (r_phase == PH_Q2) && !w_scl_s;

    i2c_stretch_timer #(.STRETCH_TO(STRETCH_TO), .TO_W(TO_W)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (r_phase != PH_Q2),
        .inc     (w_q2_low),
        .timeout (stretch_timeout)
    );

    always_comb begin
        w_phase_nx   = r_phase;
        w_cnt_nx     = r_cnt + 1'b1;
        w_div_sel_nx = r_div_sel;
        if (r_phase == PH_IDLE) begin
            w_cnt_nx = '0;
            if (ena) begin
                w_phase_nx   = PH_Q0;
                w_div_sel_nx = mode;
            end
        end else if (stretch_timeout) begin
            w_phase_nx = PH_IDLE;
            w_cnt_nx   = '0;
        end else if (w_q2_low) begin
            w_cnt_nx = r_cnt;
        end else if (w_last) begin
            w_cnt_nx   = '0;
            w_phase_nx = r_phase == PH_Q0 ? PH_Q1 :
                         r_phase == PH_Q1 ? PH_Q2 :
                         r_phase == PH_Q2 ? PH_Q3 :
                         ena              ? PH_Q0 : PH_IDLE;
            if (r_phase == PH_Q3 && ena) w_div_sel_nx = mode;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase   <= PH_IDLE;
            r_cnt     <= '0;
            r_div_sel <= I2C_MODE_STD;
        end else begin
            r_phase   <= w_phase_nx;
            r_cnt     <= w_cnt_nx;
            r_div_sel <= w_div_sel_nx;
        end
    end

    assign scl_oe       = (r_phase == PH_Q0) || (r_phase == PH_Q1);
    assign data_clk     = (r_phase == PH_Q1) || (r_phase == PH_Q2);
    assign switch_range = r_phase == PH_Q2;
    assign stretching   = w_q2_low;
    assign bit_done     = (r_phase == PH_Q3) && w_last;
    assign busy         = r_phase != PH_IDLE;
endmodule

// File: tb/tb_i2c_scl_phase_gen.sv
// tb_i2c_scl_phase_gen: randomized bit sequences with stretches, scoreboarded per-bit timing
module tb_i2c_scl_phase_gen;
    import i2c_pkg::*;
    localparam int DS = 4, DF = 2, STO = 16, N = 40;
`ifdef I2C_SCL_SYNC_EN
    localparam int LAG = 2;
`else
    localparam int LAG = 0;
`endif

    logic clk = 1'b0, rst = 1'b1, ena = 1'b0, mode = 1'b0, force_low = 1'b0;
    logic scl_in, scl_oe, data_clk, switch_range, stretching, bit_done, stretch_timeout, busy;

    assign scl_in = force_low ? 1'b0 : !scl_oe;
    always #5 clk = ~clk;

    i2c_scl_phase_gen #(.DIV_STD(DS), .DIV_FAST(DF), .CNT_W(16), .STRETCH_TO(STO), .TO_W(17)) dut (
        .clk(clk), .rst(rst), .ena(ena), .mode(mode), .scl_in(scl_in),
        .scl_oe(scl_oe), .data_clk(data_clk), .switch_range(switch_range),
        .stretching(stretching), .bit_done(bit_done),
        .stretch_timeout(stretch_timeout), .busy(busy)
    );

    typedef struct {
        logic [1:0] kind;
        int len, str, dclk, sw, oe;
    } exp_t;

    exp_t q[$];
    int n_chk = 0, n_pass = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Bit timing from the phase rules: four quarters of div plus the cycles SCL is seen low in Q2
    function automatic exp_t model(input logic m, input int l);
        exp_t e;
        int d, le;
        d  = (m == I2C_MODE_FAST) ? DF : DS;
        le = l + LAG;
        e.oe = 2 * d;
        if (le >= STO) begin
            e.kind = 2'b01;
            e.len  = 2 * d + STO;
            e.str  = STO;
            e.dclk = d + STO;
            e.sw   = STO;
        end else begin
            e.kind = 2'b10;
            e.len  = 4 * d + le;
            e.str  = le;
            e.dclk = 2 * d + le;
            e.sw   = d + le;
        end
        return e;
    endfunction

    int c_len = 0, c_str = 0, c_dclk = 0, c_sw = 0, c_oe = 0;
    logic chk_idle = 1'b0;
    exp_t me;

    always @(negedge clk) begin
        if (rst) begin
            c_len = 0; c_str = 0; c_dclk = 0; c_sw = 0; c_oe = 0;
            chk_idle = 1'b0;
        end else begin
            if (chk_idle) begin
                check("idle_after_timeout", {busy, scl_oe}, 0);
                chk_idle = 1'b0;
            end
            if (busy) begin
                c_len++;
                if (stretching) c_str++;
                if (data_clk) c_dclk++;
                if (switch_range) c_sw++;
                if (scl_oe) c_oe++;
            end
            if (bit_done || stretch_timeout) begin
                if (q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_event: bit_done=%0b timeout=%0b, nothing expected",
                             bit_done, stretch_timeout);
                end else begin
                    me = q.pop_front();
                    check("event_kind", {bit_done, stretch_timeout}, me.kind);
                    check("bit_len", c_len, me.len);
                    check("stretch_cycles", c_str, me.str);
                    check("data_clk_cycles", c_dclk, me.dclk);
                    check("switch_range_cycles", c_sw, me.sw);
                    check("scl_oe_cycles", c_oe, me.oe);
                    if (stretch_timeout) chk_idle = 1'b1;
                end
                c_len = 0; c_str = 0; c_dclk = 0; c_sw = 0; c_oe = 0;
            end
        end
    end

    logic bm[N];
    int   bl[N];
    logic bc[N];
    exp_t se;
    int   sd;
    logic cont = 1'b0;

    initial begin
        for (int b = 0; b < N; b++) begin
            int r;
            r = $urandom_range(0, 9);
            bm[b] = 1'($urandom_range(0, 1));
            bc[b] = 1'($urandom_range(0, 2) != 0);
            bl[b] = r < 5 ? $urandom_range(0, 6) : r < 7 ? $urandom_range(13, 15) : r == 7 ? 40 : 0;
        end
        bm[0] = I2C_MODE_STD;  bl[0] = 0;  bc[0] = 1'b1;
        bm[1] = I2C_MODE_FAST; bl[1] = 0;  bc[1] = 1'b1;
        bm[2] = I2C_MODE_STD;  bl[2] = 0;  bc[2] = 1'b0;
        bm[3] = I2C_MODE_STD;  bl[3] = 6;  bc[3] = 1'b0;
        bm[4] = I2C_MODE_STD;  bl[4] = 40; bc[4] = 1'b0;

        repeat (3) begin
            @(posedge clk); #1;
            check("reset_outputs", {scl_oe, data_clk, busy, bit_done}, 0);
        end
        rst = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            check("idle_ena0", {scl_oe, data_clk, busy, bit_done}, 0);
        end

        for (int b = 0; b < N; b++) begin
            se = model(bm[b], bl[b]);
            sd = (bm[b] == I2C_MODE_FAST) ? DF : DS;
            if (!cont) begin
                ena  = 1'b1;
                mode = bm[b];
            end
            q.push_back(se);
            for (int j = 1; j <= se.len; j++) begin
                @(posedge clk); #1;
                force_low = (j >= 2 * sd + 1) && (j <= 2 * sd + bl[b]);
                if (j < se.len) begin
                    ena  = 1'($urandom_range(0, 1));
                    mode = 1'($urandom_range(0, 1));
                end else begin
                    cont = (se.kind == 2'b10) && bc[b] && (b + 1 < N);
                    ena  = cont;
                    mode = cont ? bm[b + 1] : 1'($urandom_range(0, 1));
                end
            end
            if (!cont) begin
                @(posedge clk); #1;
                force_low = 1'b0;
                ena = 1'b0;
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk); #1;
                    mode = 1'($urandom_range(0, 1));
                end
            end
        end

        // abort a bit with reset while in Q2
        ena  = 1'b1;
        mode = I2C_MODE_STD;
        for (int j = 1; j <= 2 * DS + 2; j++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        check("reset_mid_q2", {busy, scl_oe, data_clk, switch_range, bit_done}, 0);
        rst = 1'b0;
        ena = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("post_reset_idle", {busy, scl_oe}, 0);
        check("scoreboard_drained", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
